// File: rtl/xmodem_response_rx.sv
// xmodem_response_rx: receive side of the xmodem sender's line interface.
// On request, waits for one UART frame on rx (start 0, 8 data bits MSB first,
// stop 1) and reports exactly one result: a byte, a timeout or a framing error.
module xmodem_response_rx #(
    parameter int CLKS_PER_BIT   = 1,
    parameter int TIMEOUT_CYCLES = 1 << 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       get_response,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       timed_out,
    output logic       framing_error,
    output logic       busy
);

    // Mid-start-bit offset; zero means the start bit is taken on the edge alone.
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW   = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_nxt;
    logic          rx_meta, rx_s, rx_prev;
    logic [TW-1:0] to_cnt, to_cnt_nxt;
    logic [BW-1:0] bit_cnt, bit_cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [7:0]    data_nxt;
    logic          data_valid_nxt, timed_out_nxt, framing_error_nxt;

    logic          start_edge;
    logic          bit_tick;
    logic [TW-1:0] to_inc;

    assign start_edge = rx_prev & ~rx_s;
    assign bit_tick   = (bit_cnt == BW'(CLKS_PER_BIT));
    assign to_inc     = to_cnt + 1'b1;
    assign busy       = (state != IDLE);

    // Next-state and datapath decode for the receive FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a value unassigned and infer a latch.
        state_nxt         = state;
        to_cnt_nxt        = to_cnt;
        bit_cnt_nxt       = bit_cnt;
        bit_idx_nxt       = bit_idx;
        shift_nxt         = shift;
        data_nxt          = data;
        data_valid_nxt    = 1'b0;
        timed_out_nxt     = 1'b0;
        framing_error_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (get_response) begin
                    state_nxt  = WAIT_START;
                    to_cnt_nxt = '0;
                end
            end

            WAIT_START: begin
                // A start edge on the final counted cycle beats the timeout.
                if (start_edge) begin
                    bit_cnt_nxt = BW'(1);
                    bit_idx_nxt = 3'd0;
                    state_nxt   = (HALF > 0) ? START : DATA;
                end else if (to_inc == TW'(TIMEOUT_CYCLES)) begin
                    timed_out_nxt = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    to_cnt_nxt = to_inc;
                end
            end

            START: begin
                // Re-check the line mid start bit; a high level was only a glitch,
                // and the timeout budget resumes where it left off.
                if (bit_cnt == BW'(HALF)) begin
                    bit_cnt_nxt = BW'(1);
                    state_nxt   = rx_s ? WAIT_START : DATA;
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end

            DATA: begin
                if (bit_tick) begin
                    shift_nxt   = {shift[6:0], rx_s};
                    bit_cnt_nxt = BW'(1);
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end

            STOP: begin
                if (bit_tick) begin
                    state_nxt = IDLE;
                    if (rx_s) begin
                        data_nxt       = shift;
                        data_valid_nxt = 1'b1;
                    end else begin
                        framing_error_nxt = 1'b1;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // State, synchroniser, counters and registered result pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rx_meta       <= 1'b1;
            rx_s          <= 1'b1;
            rx_prev       <= 1'b1;
            to_cnt        <= '0;
            bit_cnt       <= '0;
            bit_idx       <= 3'd0;
            shift         <= 8'h00;
            data          <= 8'h00;
            data_valid    <= 1'b0;
            timed_out     <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so the synchroniser chain shifts
            // by one stage per clock instead of collapsing into a single wire.
            rx_meta       <= rx;
            rx_s          <= rx_meta;
            rx_prev       <= rx_s;
            state         <= state_nxt;
            to_cnt        <= to_cnt_nxt;
            bit_cnt       <= bit_cnt_nxt;
            bit_idx       <= bit_idx_nxt;
            shift         <= shift_nxt;
            data          <= data_nxt;
            data_valid    <= data_valid_nxt;
            timed_out     <= timed_out_nxt;
            framing_error <= framing_error_nxt;
        end
    end

endmodule
